// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   ctrl_state_t     : sequencer states (RUN, LU_BUB, MEM_WAIT)
//   REG_ZERO         : architectural x0; never a real dependency
//   MAX_WAIT_DEFAULT : default memory-wait cycles before the watchdog trips
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_BUB   = 2'd1,
    MEM_WAIT = 2'd2
  } ctrl_state_t;

  localparam logic [4:0] REG_ZERO         = 5'd0;
  localparam int         MAX_WAIT_DEFAULT = 64;

endpackage

// File: rtl/pipeline_ctrl_wait_watchdog.sv
// wait_watchdog: counts consecutive data-memory wait cycles and raises a
// sticky timeout flag once the count reaches MAX_WAIT.
// Ports:
//   clk        in  clock
//   rst        in  asynchronous active-high reset
//   wait_cycle in  pipe is frozen on dmem this cycle
//   timeout    out sticky flag, cleared only by rst
// The counter saturates at MAX_WAIT and clears on any non-wait cycle, which
// covers leaving MEM_WAIT. CNT_W must satisfy 2**CNT_W > MAX_WAIT.
module wait_watchdog
  import pipe_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT,
  parameter int CNT_W    = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic wait_cycle,
  output logic timeout
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             timeout_reg;

  always_comb begin
    cnt_next = '0;
    if (wait_cycle) begin
      cnt_next = (cnt_reg == MAX_CNT) ? cnt_reg : cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      // Flag rises on the same edge that the count reaches the limit.
      if (wait_cycle && cnt_next == MAX_CNT) begin
        timeout_reg <= 1'b1;
      end
    end
  end

  assign timeout = timeout_reg;

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Resolves load-use (one bubble), taken branch/jump (flush D and E) and
// multi-cycle dmem access (freeze whole pipe), with a wait watchdog.
// Ports:
//   clk, rst (async, active-high)
//   Rs1_D, Rs2_D, Rd_E, MemRead_E, PCSrc_E, MemReq_M, MemReady_M : hazard inputs
//   Stall_F, Stall_D, Flush_D, Stall_E, Flush_E, Stall_M, Flush_W : stage controls
//   Timeout_M : sticky watchdog error
//   PerfStall_o, PerfFlush_o : only when PIPELINE_CTRL_PERF_EN is defined
// Stage controls are combinational from state plus inputs; state, watchdog
// and perf counters are registered.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT,
  parameter int CNT_W    = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1_D,
  input  logic [4:0]  Rs2_D,
  input  logic [4:0]  Rd_E,
  input  logic        MemRead_E,
  input  logic        PCSrc_E,
  input  logic        MemReq_M,
  input  logic        MemReady_M,
  output logic        Stall_F,
  output logic        Stall_D,
  output logic        Flush_D,
  output logic        Stall_E,
  output logic        Flush_E,
  output logic        Stall_M,
  output logic        Flush_W,
`ifdef PIPELINE_CTRL_PERF_EN
  output logic [31:0] PerfStall_o,
  output logic [31:0] PerfFlush_o,
`endif
  output logic        Timeout_M
);

  ctrl_state_t state_reg;
  ctrl_state_t state_next;

  logic lu;
  logic freeze;
  logic branch_flush;

  assign lu = MemRead_E && (Rd_E != REG_ZERO) && ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));
  assign freeze       = MemReq_M && !MemReady_M;
  assign branch_flush = !rst && !freeze && PCSrc_E;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Priority freeze > PCSrc_E > lu. The ready cycle leaving MEM_WAIT falls
  // through to the normal rules, so a held lu there still gets its bubble.
  // Outputs are forced low during reset regardless of the inputs.
  always_comb begin
    state_next = state_reg;
    Stall_F    = 1'b0;
    Stall_D    = 1'b0;
    Flush_D    = 1'b0;
    Stall_E    = 1'b0;
    Flush_E    = 1'b0;
    Stall_M    = 1'b0;
    Flush_W    = 1'b0;
    if (!rst) begin
      if (freeze) begin
        Stall_F    = 1'b1;
        Stall_D    = 1'b1;
        Stall_E    = 1'b1;
        Stall_M    = 1'b1;
        Flush_W    = 1'b1;
        state_next = MEM_WAIT;
      end else if (PCSrc_E) begin
        Flush_D    = 1'b1;
        Flush_E    = 1'b1;
        state_next = RUN;
      end else if (lu && state_reg != LU_BUB) begin
        Stall_F    = 1'b1;
        Stall_D    = 1'b1;
        Flush_E    = 1'b1;
        state_next = LU_BUB;
      end else begin
        state_next = RUN;
      end
    end
  end

  wait_watchdog #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .wait_cycle (freeze),
    .timeout    (Timeout_M)
  );

`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] perf_stall_reg;
  logic [31:0] perf_flush_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_reg <= '0;
      perf_flush_reg <= '0;
    end else begin
      if (Stall_F) begin
        perf_stall_reg <= perf_stall_reg + 32'd1;
      end
      if (branch_flush) begin
        perf_flush_reg <= perf_flush_reg + 32'd1;
      end
    end
  end

  assign PerfStall_o = perf_stall_reg;
  assign PerfFlush_o = perf_flush_reg;
`else
  logic unused_branch_flush;
  assign unused_branch_flush = branch_flush;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Table-driven bench for pipeline_ctrl (MAX_WAIT=4). Each table row is one
// clock cycle: inputs plus expected {Stall_F,Stall_D,Flush_D,Stall_E,
// Flush_E,Stall_M,Flush_W,Timeout_M}. Rows run back to back from reset so
// state carries between them. Hand sequences cover reset behaviour.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1_D, Rs2_D, Rd_E;
  logic       MemRead_E, PCSrc_E, MemReq_M, MemReady_M;
  logic       Stall_F, Stall_D, Flush_D, Stall_E, Flush_E, Stall_M, Flush_W, Timeout_M;
`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] PerfStall_o, PerfFlush_o;
`endif

  always #5 clk = ~clk;

  pipeline_ctrl #(.MAX_WAIT(4), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .Rs1_D      (Rs1_D),
    .Rs2_D      (Rs2_D),
    .Rd_E       (Rd_E),
    .MemRead_E  (MemRead_E),
    .PCSrc_E    (PCSrc_E),
    .MemReq_M   (MemReq_M),
    .MemReady_M (MemReady_M),
    .Stall_F    (Stall_F),
    .Stall_D    (Stall_D),
    .Flush_D    (Flush_D),
    .Stall_E    (Stall_E),
    .Flush_E    (Flush_E),
    .Stall_M    (Stall_M),
    .Flush_W    (Flush_W),
`ifdef PIPELINE_CTRL_PERF_EN
    .PerfStall_o(PerfStall_o),
    .PerfFlush_o(PerfFlush_o),
`endif
    .Timeout_M  (Timeout_M)
  );

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       mr;
    logic       pc;
    logic       mq;
    logic       my;
    logic [7:0] exp;
  } vec_t;

  localparam logic [7:0] O_NONE = 8'b0000_0000;
  localparam logic [7:0] O_LU   = 8'b1100_1000;
  localparam logic [7:0] O_BR   = 8'b0010_1000;
  localparam logic [7:0] O_FRZ  = 8'b1101_0110;

  localparam int NV = 31;
  vec_t vecs [NV];

  int checks   = 0;
  int failures = 0;
  int exp_stall_cnt = 0;
  int exp_flush_cnt = 0;

  function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic mr, input logic pc,
                              input logic mq, input logic my, input logic [7:0] exp);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.mr = mr; v.pc = pc;
    v.mq = mq; v.my = my; v.exp = exp;
    return v;
  endfunction

  function automatic logic [7:0] outs();
    return {Stall_F, Stall_D, Flush_D, Stall_E, Flush_E, Stall_M, Flush_W, Timeout_M};
  endfunction

  task automatic drive(input vec_t v);
    Rs1_D = v.rs1; Rs2_D = v.rs2; Rd_E = v.rd; MemRead_E = v.mr;
    PCSrc_E = v.pc; MemReq_M = v.mq; MemReady_M = v.my;
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end else begin
      $display("ok   %s: %b", name, act);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  initial begin
    // rs1, rs2, rd, mr, pc, mq, my, expected
    vecs[0]  = mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, O_NONE);          // idle
    vecs[1]  = mk(5'd5, 5'd0, 5'd5, 1, 0, 0, 0, O_LU);            // load-use rs1
    vecs[2]  = mk(5'd5, 5'd0, 5'd5, 1, 0, 0, 0, O_NONE);          // LU_BUB, held inputs
    vecs[3]  = mk(5'd3, 5'd7, 5'd7, 1, 0, 0, 0, O_LU);            // load-use rs2
    vecs[4]  = mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, O_NONE);          // LU_BUB idle
    vecs[5]  = mk(5'd0, 5'd0, 5'd0, 1, 0, 0, 0, O_NONE);          // x0 immunity
    vecs[6]  = mk(5'd5, 5'd0, 5'd5, 0, 0, 0, 0, O_NONE);          // not a load
    vecs[7]  = mk(5'd5, 5'd0, 5'd5, 1, 1, 0, 0, O_BR);            // branch beats lu
    vecs[8]  = mk(5'd5, 5'd0, 5'd5, 1, 0, 0, 0, O_LU);            // still RUN -> bubble
    vecs[9]  = mk(5'd0, 5'd0, 5'd0, 0, 1, 0, 0, O_BR);            // branch in LU_BUB
    vecs[10] = mk(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, O_FRZ);           // wait 1
    vecs[11] = mk(5'd5, 5'd0, 5'd5, 1, 1, 1, 0, O_FRZ);           // wait 2, freeze beats all
    vecs[12] = mk(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, O_FRZ);           // wait 3
    vecs[13] = mk(5'd5, 5'd0, 5'd5, 1, 0, 1, 1, O_LU);            // ready, lu re-evaluated
    vecs[14] = mk(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, O_FRZ);           // counter restarted at 1
    vecs[15] = mk(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, O_FRZ);
    vecs[16] = mk(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, O_FRZ);
    vecs[17] = mk(5'd0, 5'd0, 5'd0, 0, 0, 1, 1, O_NONE);          // ready, all stalls drop
    vecs[18] = mk(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, O_FRZ);
    vecs[19] = mk(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, O_FRZ);
    vecs[20] = mk(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, O_FRZ);
    vecs[21] = mk(5'd0, 5'd0, 5'd0, 0, 0, 1, 1, O_NONE);
    vecs[22] = mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, O_NONE);          // no timeout yet
    vecs[23] = mk(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, O_FRZ);           // watchdog run
    vecs[24] = mk(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, O_FRZ);
    vecs[25] = mk(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, O_FRZ);
    vecs[26] = mk(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, O_FRZ);           // 4th wait cycle
    vecs[27] = mk(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, O_FRZ | 8'd1);    // timeout up
    vecs[28] = mk(5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 8'd1);            // ready, sticky
    vecs[29] = mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 8'd1);
    vecs[30] = mk(5'd0, 5'd0, 5'd0, 0, 1, 0, 0, O_BR | 8'd1);

    // Reset held with hazardous inputs: everything must stay low.
    rst = 1'b1;
    drive(mk(5'd5, 5'd0, 5'd5, 1, 1, 1, 0, O_NONE));
    #12;
    check8("reset_outputs", outs(), O_NONE);
    @(negedge clk);
    rst = 1'b0;
    drive(mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, O_NONE));
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      check8($sformatf("vec%0d", i), outs(), vecs[i].exp);
      if (vecs[i].exp[7]) exp_stall_cnt++;
      if (vecs[i].exp[5]) exp_flush_cnt++;
      @(posedge clk); #1;
    end

`ifdef PIPELINE_CTRL_PERF_EN
    check32("perf_stall", PerfStall_o, 32'(exp_stall_cnt));
    check32("perf_flush", PerfFlush_o, 32'(exp_flush_cnt));
`endif

    // Async reset while in MEM_WAIT, asserted mid-cycle with freeze still driven.
    drive(mk(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, O_NONE));
    @(posedge clk); #1;
    @(negedge clk);
    check8("memwait_before_rst", outs(), O_FRZ | 8'd1);
    #2;
    rst = 1'b1;
    #1;
    check8("async_rst_outputs", outs(), O_NONE);
`ifdef PIPELINE_CTRL_PERF_EN
    check32("perf_stall_rst", PerfStall_o, 32'd0);
    check32("perf_flush_rst", PerfFlush_o, 32'd0);
`endif
    drive(mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, O_NONE));
    @(negedge clk);
    rst = 1'b0;
    // Back in RUN with watchdog cleared: a load-use must stall immediately.
    drive(mk(5'd9, 5'd0, 5'd9, 1, 0, 0, 0, O_NONE));
    #1;
    check8("post_rst_lu", outs(), O_LU);
    @(posedge clk); #1;
    check8("post_rst_bubble", outs(), O_NONE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "time budget exceeded");
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Stall/flush sequencer for the 5-stage RV64I-Zba pipeline. Sits beside the forwarding unit.
- Resolves the hazards forwarding cannot fix:
  - load-use dependencies (one bubble),
  - taken branches/jumps (flush D and E),
  - multi-cycle data-memory accesses (whole-pipe freeze).
- Drives every stage-register enable/clear. Includes a wait-cycle watchdog.

Parameters:
- MAX_WAIT, 64: memory-wait cycles before Timeout_M asserts.
- CNT_W, 7: watchdog counter width. Must satisfy 2**CNT_W > MAX_WAIT.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- Rs1_D  in  5  rs1 of instruction in Decode.
- Rs2_D  in  5  rs2 of instruction in Decode.
- Rd_E  in  5  rd of instruction in Execute.
- MemRead_E  in  1  instruction in Execute is a load.
- PCSrc_E  in  1  taken branch/jump resolved in Execute.
- MemReq_M  in  1  Memory-stage instruction accesses dmem.
- MemReady_M  in  1  dmem completes the access this cycle.
- Stall_F  out  1  hold PC.
- Stall_D  out  1  hold IF/ID register.
- Flush_D  out  1  clear IF/ID to NOP.
- Stall_E  out  1  hold ID/EX register.
- Flush_E  out  1  clear ID/EX to NOP.
- Stall_M  out  1  hold EX/MEM register.
- Flush_W  out  1  clear MEM/WB to NOP (bubble into Writeback).
- Timeout_M  out  1  sticky watchdog error.

Behaviour:
- Reset: state=RUN, wait counter=0, Timeout_M=0. All outputs 0 while rst is high.
- States:
  - RUN: normal flow.
  - LU_BUB: one load-use bubble issued.
  - MEM_WAIT: dmem access outstanding.
- Definitions:
  - lu = MemRead_E && Rd_E!=0 && (Rd_E==Rs1_D || Rd_E==Rs2_D).
  - freeze = MemReq_M && !MemReady_M.
- Priority: freeze > PCSrc_E > lu.
- freeze (any state):
  - Outputs: Stall_F=Stall_D=Stall_E=Stall_M=1, Flush_W=1. All other flushes 0.
  - Next state: MEM_WAIT.
  - Counter increments, saturating at MAX_WAIT.
- MEM_WAIT exit:
  - Leaves when MemReady_M=1, in the same cycle: stalls drop and the pipe advances.
  - Counter clears on exit.
  - Held PCSrc_E/lu are re-evaluated that cycle under normal rules.
- PCSrc_E (no freeze):
  - Flush_D=1, Flush_E=1, no stalls.
  - Overrides lu: the dependent instruction is squashed, so no bubble is issued.
  - Next state RUN.
- lu (no freeze, no PCSrc_E, state RUN):
  - Stall_F=1, Stall_D=1, Flush_E=1.
  - Next state LU_BUB.
- LU_BUB:
  - No lu stall is issued regardless of inputs; the load has moved to M and forwarding covers it.
  - Returns to RUN next cycle unless freeze applies.
- Watchdog:
  - Timeout_M sets when the counter reaches MAX_WAIT.
  - Stays set until rst. The pipeline keeps waiting.
- Latency:
  - Stall/flush outputs are combinational from state plus inputs (same-cycle).
  - State, counter and Timeout_M are registered.
- Reset mid-operation: async return to RUN, counter 0, outputs 0 immediately.

Optional Feature:
- Macro: PIPELINE_CTRL_PERF_EN.
- Defined, adds outputs:
  - PerfStall_o[31:0]: counts cycles with Stall_F=1.
  - PerfFlush_o[31:0]: counts cycles with PCSrc_E flush.
  - Both counters wrap modulo 2^32 and clear on rst.
- Undefined: these ports and counters do not exist. Control behaviour is identical in both builds.

Decomposition:
- Shared package pipe_pkg holds:
  - enum ctrl_state_t {RUN, LU_BUB, MEM_WAIT},
  - REG_ZERO=5'd0,
  - default MAX_WAIT constant.
- One natural sub-module, wait_watchdog: saturating counter plus sticky flag, parameterized by MAX_WAIT and CNT_W.

Test Plan:
- Load-use: MemRead_E=1, Rd_E=5, Rs1_D=5.
  - Expect one cycle of Stall_F=Stall_D=Flush_E=1.
  - Next cycle, with the same inputs held, all outputs are 0 (LU_BUB).
- x0 immunity: MemRead_E=1, Rd_E=0, Rs2_D=0 → no stall, no flush.
- Branch vs load-use: PCSrc_E=1 with lu true.
  - Expect Flush_D=Flush_E=1, Stall_F=0.
  - State stays RUN.
- Memory wait: MemReq_M=1, MemReady_M=0 for 3 cycles, then 1.
  - Expect 3 cycles of all stalls plus Flush_W.
  - On the ready cycle all stalls are 0; counter reads 0 afterward.
- Watchdog: MAX_WAIT=4, MemReady_M held 0.
  - Timeout_M rises after the 4th wait cycle.
  - Stays 1 after ready returns; clears only on rst.
- Async reset in MEM_WAIT: assert rst between clk edges.
  - Outputs 0 immediately, state RUN.
  - PIPELINE_CTRL_PERF_EN build: perf counters read 0.
